// File: rtl/hub75_scan_engine.sv
// hub75_scan_engine
// -----------------
// Scans a 4096 x 12-bit RGB444 framebuffer out to a HUB75 panel.
// For each row pair it shifts one bit-plane of the top and bottom half.
// It then latches the plane and lights it for BASE_TICKS << plane cycles.
// There are 4 planes per row and 16 rows per frame.
//
// Ports
//   clk          system clock, rising edge
//   gls_reset    synchronous active-high reset
//   enable       start / keep scanning (looked at in IDLE and at frame end)
//   fb_addr      registered framebuffer read address
//   fb_data      framebuffer read data, one cycle behind fb_addr
//   s_clk        panel shift clock
//   s_r_t..s_b_b serial colour bits, top and bottom half
//   latch        panel latch, active high
//   noe          panel output enable, active low
//   mux          row-pair select
//   busy         high whenever not IDLE
//   frame_done   one-cycle pulse after the last plane of row 15

module hub75_scan_engine #(
   parameter int BASE_TICKS = 64
) (
   input  logic        clk,
   input  logic        gls_reset,
   input  logic        enable,
   output logic [11:0] fb_addr,
   input  logic [11:0] fb_data,
   output logic        s_clk,
   output logic        s_r_t,
   output logic        s_g_t,
   output logic        s_b_t,
   output logic        s_r_b,
   output logic        s_g_b,
   output logic        s_b_b,
   output logic        latch,
   output logic        noe,
   output logic [3:0]  mux,
   output logic        busy,
   output logic        frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH_T,
      FETCH_B,
      SHIFT_LO,
      SHIFT_HI,
      BLANK,
      LATCH,
      DISPLAY
   } state_t;

   localparam logic [15:0] BASE_T16 = 16'(BASE_TICKS);

   state_t      state;
   state_t      next_state;

   logic [6:0]  col;
   logic [1:0]  plane;
   logic [3:0]  row;
   logic [15:0] disp;
   logic [11:0] top_pix;
   logic [11:0] bot_pix;

   logic [6:0]  col_nxt;
   logic [1:0]  plane_nxt;
   logic [3:0]  row_nxt;
   logic [15:0] disp_nxt;
   logic [11:0] fb_addr_nxt;
   logic [11:0] bot_src;

   logic        last_col;
   logic        disp_last;
   logic        frame_end;

   assign last_col  = (col == 7'd127);
   // "<= 1" rather than "== 1" so a zero weight cannot wrap into a 64k-cycle display
   assign disp_last = (disp <= 16'd1);
   assign frame_end = (state == DISPLAY) && disp_last && (plane == 2'd3) && (row == 4'd15);

   // State register
   always_ff @(posedge clk) begin
      if (gls_reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic; enable only matters in IDLE and on the last plane of a frame
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (enable) next_state = FETCH_T;
         FETCH_T:  next_state = FETCH_B;
         FETCH_B:  next_state = SHIFT_LO;
         SHIFT_LO: next_state = SHIFT_HI;
         SHIFT_HI: next_state = last_col ? BLANK : FETCH_T;
         BLANK:    next_state = LATCH;
         LATCH:    next_state = DISPLAY;
         DISPLAY: begin
            if (disp_last) begin
               if (frame_end && !enable)
                  next_state = IDLE;
               else
                  next_state = FETCH_T;
            end
         end
         default:  next_state = IDLE;
      endcase
   end

   // Counter next values.
   // Also selects the address to present next cycle, so fb_addr is already valid in FETCH_T and FETCH_B.
   always_comb begin
      col_nxt     = col;
      plane_nxt   = plane;
      row_nxt     = row;
      disp_nxt    = disp;
      fb_addr_nxt = fb_addr;
      case (state)
         IDLE: begin
            if (enable) begin
               col_nxt   = 7'd0;
               plane_nxt = 2'd0;
               row_nxt   = 4'd0;
            end
         end
         SHIFT_HI: begin
            if (!last_col) col_nxt = col + 7'd1;
         end
         LATCH: begin
            disp_nxt = BASE_T16 << plane;
         end
         DISPLAY: begin
            disp_nxt = disp - 16'd1;
            if (disp_last) begin
               col_nxt = 7'd0;
               if (plane == 2'd3) begin
                  plane_nxt = 2'd0;
                  row_nxt   = row + 4'd1;
               end else begin
                  plane_nxt = plane + 2'd1;
               end
            end
         end
         default: ;
      endcase
      if (next_state == FETCH_T)
         fb_addr_nxt = {1'b0, row_nxt, col_nxt};
      else if (next_state == FETCH_B)
         fb_addr_nxt = {1'b1, row, col};
   end

   // Datapath registers.
   // The top pixel arrives in FETCH_B and the bottom pixel in SHIFT_LO.
   // mux only moves in BLANK, while the panel is dark.
   always_ff @(posedge clk) begin
      if (gls_reset) begin
         col        <= 7'd0;
         plane      <= 2'd0;
         row        <= 4'd0;
         disp       <= 16'd0;
         fb_addr    <= 12'd0;
         mux        <= 4'd0;
         top_pix    <= 12'd0;
         bot_pix    <= 12'd0;
         frame_done <= 1'b0;
      end else begin
         col        <= col_nxt;
         plane      <= plane_nxt;
         row        <= row_nxt;
         disp       <= disp_nxt;
         fb_addr    <= fb_addr_nxt;
         frame_done <= frame_end;
         if (state == BLANK)    mux     <= row;
         if (state == FETCH_B)  top_pix <= fb_data;
         if (state == SHIFT_LO) bot_pix <= fb_data;
      end
   end

   // Output decode.
   // In SHIFT_LO the bottom pixel is still on fb_data, so it is used directly.
   // The copy in bot_pix then holds the colours through SHIFT_HI.
   always_comb begin
      bot_src = (state == SHIFT_LO) ? fb_data : bot_pix;
      s_clk   = (state == SHIFT_HI);
      latch   = (state == LATCH);
      noe     = (state != DISPLAY);
      busy    = (state != IDLE);
      s_r_t   = top_pix[{2'b10, plane}];
      s_g_t   = top_pix[{2'b01, plane}];
      s_b_t   = top_pix[{2'b00, plane}];
      s_r_b   = bot_src[{2'b10, plane}];
      s_g_b   = bot_src[{2'b01, plane}];
      s_b_b   = bot_src[{2'b00, plane}];
   end

endmodule

// File: tb/tb_hub75_scan_engine.sv
// tb_hub75_scan_engine
// --------------------
// Bench for hub75_scan_engine.
// A behavioural RAM holds a random framebuffer.
// Panel outputs are compared against figures worked out from the scan rules:
//   - the colour bits for the n-th shift pulse
//   - the cycle of every latch
//   - the noe-low length per plane
//   - the frame length

module tb_hub75_scan_engine;

   localparam int BASE_TICKS = 64;

   logic        clk = 1'b0;
   logic        gls_reset;
   logic        enable;
   logic [11:0] fb_addr;
   logic [11:0] fb_data;
   logic        s_clk;
   logic        s_r_t, s_g_t, s_b_t, s_r_b, s_g_b, s_b_b;
   logic        latch;
   logic        noe;
   logic [3:0]  mux;
   logic        busy;
   logic        frame_done;

   logic [11:0] fb_mem [0:4095];

   int tests_run    = 0;
   int tests_failed = 0;

   // Monitor state
   int          cyc;
   int          rise_idx;
   int          latch_idx;
   int          noe_idx;
   int          run_len;
   int          fd_seen;
   int          fd_cycle;
   logic        prev_sclk, prev_noe, prev_latch, prev_fd;
   logic [3:0]  prev_mux;
   logic [5:0]  prev_obs;
   logic [3:0]  bs_r, bs_g, bs_b;

   hub75_scan_engine #(.BASE_TICKS(BASE_TICKS)) dut (
      .clk        (clk),
      .gls_reset  (gls_reset),
      .enable     (enable),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .s_clk      (s_clk),
      .s_r_t      (s_r_t),
      .s_g_t      (s_g_t),
      .s_b_t      (s_b_t),
      .s_r_b      (s_r_b),
      .s_g_b      (s_g_b),
      .s_b_b      (s_b_b),
      .latch      (latch),
      .noe        (noe),
      .mux        (mux),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Framebuffer RAM with one cycle of read latency
   always @(posedge clk) fb_data <= fb_mem[fb_addr];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en);
      gls_reset = rst;
      enable    = en;
   endtask

   function automatic int planeTicks(input int p);
      return BASE_TICKS << p;
   endfunction

   // Cycle of the k-th latch, where cycle 1 is the first cycle after enable is taken.
   // Each plane is 512 shift cycles, then BLANK, then LATCH, then its display time.
   function automatic int latchCycle(input int k);
      int c = 1;
      for (int j = 0; j < k; j++) c += 4 * 128 + 2 + planeTicks(j % 4);
      return c + 4 * 128 + 1;
   endfunction

   function automatic int frameDoneCycle();
      int c = 1;
      for (int j = 0; j < 64; j++) c += 4 * 128 + 2 + planeTicks(j % 4);
      return c;
   endfunction

   // Colour bits {r_t,g_t,b_t,r_b,g_b,b_b} expected on the n-th shift pulse of a frame
   function automatic logic [5:0] expColours(input int n);
      int r = n / 512;
      int p = (n / 128) % 4;
      int c = n % 128;
      logic [11:0] t = fb_mem[r * 128 + c];
      logic [11:0] b = fb_mem[2048 + r * 128 + c];
      return {t[8 + p], t[4 + p], t[p], b[8 + p], b[4 + p], b[p]};
   endfunction

   task automatic fillMemory();
      for (int i = 0; i < 4096; i++) fb_mem[i] = 12'($urandom);
      fb_mem[0]    = 12'hF00;
      fb_mem[2048] = 12'h00F;
      fb_mem[5]    = 12'h8C3;
   endtask

   task automatic resetMonitor();
      cyc        = 0;
      rise_idx   = 0;
      latch_idx  = 0;
      noe_idx    = 0;
      run_len    = 0;
      fd_seen    = 0;
      fd_cycle   = 0;
      prev_sclk  = 1'b0;
      prev_noe   = 1'b1;
      prev_latch = 1'b0;
      prev_fd    = 1'b0;
      prev_mux   = mux;
      prev_obs   = 6'd0;
      bs_r       = 4'd0;
      bs_g       = 4'd0;
      bs_b       = 4'd0;
   endtask

   task automatic checkIdleOutputs(input string where);
      checkOutput({where, "_noe"},        32'(noe),        32'd1);
      checkOutput({where, "_latch"},      32'(latch),      32'd0);
      checkOutput({where, "_s_clk"},      32'(s_clk),      32'd0);
      checkOutput({where, "_busy"},       32'(busy),       32'd0);
      checkOutput({where, "_mux"},        32'(mux),        32'd0);
      checkOutput({where, "_fb_addr"},    32'(fb_addr),    32'd0);
      checkOutput({where, "_frame_done"}, 32'(frame_done), 32'd0);
      checkOutput({where, "_colours"},
                  32'({s_r_t, s_g_t, s_b_t, s_r_b, s_g_b, s_b_b}), 32'd0);
   endtask

   // Called once per cycle at the falling edge, while a scan is running
   task automatic sampleCycle();
      logic [5:0] obs;
      logic [5:0] exp_c;
      cyc++;
      obs = {s_r_t, s_g_t, s_b_t, s_r_b, s_g_b, s_b_b};

      if (cyc == 1) begin
         checkOutput("first_addr_top", 32'(fb_addr), 32'd0);
         checkOutput("busy_after_start", 32'(busy), 32'd1);
      end
      if (cyc == 2) checkOutput("first_addr_bottom", 32'(fb_addr), 32'd2048);

      if (s_clk && !prev_sclk) begin
         exp_c = expColours(rise_idx);
         if (rise_idx == 0) begin
            checkOutput("first_rise_cycle", 32'(cyc), 32'd4);
            checkOutput("first_rise_bits", 32'({obs[5:2], obs[0]}), 32'b10001);
         end
         checkOutput("colour_before_rise", 32'(prev_obs), 32'(exp_c));
         checkOutput("colour_at_rise", 32'(obs), 32'(exp_c));
         if (rise_idx < 512 && (rise_idx % 128) == 5) begin
            bs_r[rise_idx / 128] = obs[5];
            bs_g[rise_idx / 128] = obs[4];
            bs_b[rise_idx / 128] = obs[3];
         end
         rise_idx++;
      end

      if (latch) begin
         checkOutput("latch_cycle", 32'(cyc), 32'(latchCycle(latch_idx)));
         checkOutput("rises_before_latch", 32'(rise_idx), 32'(128 * (latch_idx + 1)));
         checkOutput("latch_width", 32'(prev_latch), 32'd0);
         checkOutput("latch_while_dark", 32'(noe), 32'd1);
         latch_idx++;
      end

      if (!noe) begin
         if (prev_noe) begin
            checkOutput("noe_fall_cycle", 32'(cyc), 32'(latchCycle(noe_idx) + 1));
            checkOutput("mux_row", 32'(mux), 32'(noe_idx / 4));
         end
         run_len++;
      end else if (!prev_noe) begin
         checkOutput("noe_low_length", 32'(run_len), 32'(planeTicks(noe_idx % 4)));
         noe_idx++;
         run_len = 0;
      end

      if (mux !== prev_mux) checkOutput("mux_change_dark", 32'(noe), 32'd1);

      if (frame_done) begin
         checkOutput("frame_done_cycle", 32'(cyc), 32'(frameDoneCycle()));
         checkOutput("frame_done_width", 32'(prev_fd), 32'd0);
         fd_seen++;
         fd_cycle = cyc;
      end

      prev_sclk  = s_clk;
      prev_noe   = noe;
      prev_latch = latch;
      prev_fd    = frame_done;
      prev_mux   = mux;
      prev_obs   = obs;
   endtask

   initial begin
      fillMemory();
      applyStimulus(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset");
      applyStimulus(1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("idle_hold_busy", 32'(busy), 32'd0);

      // Scan row 0 fully, then stop partway into the row 1 plane 0 display
      resetMonitor();
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 3560; i++) begin
         @(negedge clk);
         sampleCycle();
      end
      checkOutput("rows_row0_noe_runs", 32'(noe_idx), 32'd4);
      checkOutput("bitsel_r", 32'(bs_r), 32'b1000);
      checkOutput("bitsel_g", 32'(bs_g), 32'b1100);
      checkOutput("bitsel_b", 32'(bs_b), 32'b0011);
      checkOutput("pre_reset_noe", 32'(noe), 32'd0);
      checkOutput("pre_reset_mux", 32'(mux), 32'd1);

      // Reset in the middle of DISPLAY, with enable dropped at the same time
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      checkIdleOutputs("mid_reset");
      repeat (2) @(negedge clk);
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("idle_after_reset_busy", 32'(busy), 32'd0);
      end
      checkOutput("idle_after_reset_noe", 32'(noe), 32'd1);

      // Full frame on new random contents.
      // enable drops partway through, so the frame must finish and then go idle.
      fillMemory();
      resetMonitor();
      applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 49000 && !(fd_seen > 0 && cyc >= fd_cycle + 4); i++) begin
         @(negedge clk);
         sampleCycle();
         if (cyc == 20000) applyStimulus(1'b0, 1'b0);
      end
      checkOutput("frame_done_seen", 32'(fd_seen), 32'd1);
      checkOutput("frame_rises", 32'(rise_idx), 32'd8192);
      checkOutput("frame_noe_runs", 32'(noe_idx), 32'd64);
      checkOutput("end_idle_busy", 32'(busy), 32'd0);
      checkOutput("end_idle_noe", 32'(noe), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hub75_scan_engine.md
# hub75_scan_engine

Scan engine feeding the HUB75 connector: reads a 4096-pixel, 12-bit RGB444 framebuffer through a 1-cycle-latency read port. Serialises one bit-plane of a top/bottom row pair into the panel shift registers, latches it and displays it for a binary-weighted time. It runs 4 planes per row and 16 rows per frame. It sits between the framebuffer RAM (written from the GPMC/Wishbone side) and the HUB_* / S_OUT pins.

## Interface
- BASE_TICKS, 64: display cycles for plane 0; plane p displays BASE_TICKS << p cycles.
- clk  in  1  system clock; all logic on rising edge.
- gls_reset  in  1  synchronous, active-high reset.
- enable  in  1  start or continue scanning; sampled only in IDLE and at frame end.
- fb_addr  out  12  framebuffer read address, registered.
- fb_data  in  12  read data for the previous cycle's fb_addr; [11:8]=R, [7:4]=G, [3:0]=B.
- s_clk  out  1  panel shift clock.
- s_r_t, s_g_t, s_b_t, s_r_b, s_g_b, s_b_b  out  1 each  serial colour bits, top/bottom half.
- latch  out  1  panel latch, active high.
- noe  out  1  output enable, active low.
- mux  out  4  row-pair select.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at end of each frame.

## Operation
- Counters: col (7 bit, 0..127), plane (2 bit, 0..3), row (4 bit, 0..15), disp (16 bit).
- Address map: top = {1'b0,row,col}; bottom = {1'b1,row,col}.
- Colour bit for plane p: R = pixel[8+p], G = pixel[4+p], B = pixel[p].
- States:
  - IDLE: noe=1. If enable, go to FETCH_T with col=plane=row=0.
  - FETCH_T: fb_addr=top.
  - FETCH_B: fb_addr=bottom; capture fb_data as top pixel.
  - SHIFT_LO: s_clk=0; colour outputs driven from the captured top pixel and fb_data (bottom).
  - SHIFT_HI: s_clk=1, colours held. If col<127, col+1 and go to FETCH_T; else go to BLANK.
  - BLANK: noe=1, mux<=row. 1 cycle.
  - LATCH: latch=1. 1 cycle. disp loads BASE_TICKS<<plane.
  - DISPLAY: noe=0, disp decrements; leave when disp reaches 1. On exit noe=1, col=0, and the counters advance as follows:
    - plane<3: plane+1.
    - plane=3: plane=0, row+1.
    - row=15 and plane=3: frame_done=1 for one cycle. Go to FETCH_T if enable, else IDLE.
- noe is 1 in every state except DISPLAY. The panel is dark while shifting.
- The enable level outside IDLE and frame end is ignored; a frame in progress always completes.

## Timing
- Reset values: s_clk=0, all colour outputs 0, latch=0, noe=1, mux=0, fb_addr=0, busy=0, frame_done=0, state IDLE, all counters 0.
- Reset mid-operation forces these values on the next edge regardless of state. No partial latch is issued.
- Per column: 4 cycles. s_clk rises once per column; colours are stable for the full cycle before and after the rise.
- Per plane: 512 shift cycles + 1 BLANK + 1 LATCH + (BASE_TICKS<<p) DISPLAY cycles.
- Per row with BASE_TICKS=64: 4*514 + 960 = 3016 cycles.
- Per frame: 48256 cycles. With enable held high, consecutive frame_done pulses are 48256 cycles apart.
- Start latency: enable high in IDLE leads to FETCH_T on the next cycle. First s_clk rise is 4 cycles after leaving IDLE.
- mux changes only in BLANK, while noe=1. latch is never high while noe=0.

## Test plan
- Reset: hold gls_reset 3 cycles mid-DISPLAY -> next cycle noe=1, mux=0, latch=0, busy=0; stays in IDLE with enable low.
- First column: RAM with addr 0 = 12'hF00 and addr 2048 = 12'h00F; raise enable.
  - fb_addr sequence is 0, 2048.
  - At the first s_clk rise: s_r_t=1, s_g_t=0, s_b_t=0, s_b_b=1, s_r_b=0.
- Plane shift: count s_clk rises between enable and the first latch -> exactly 128.
  - latch is high 1 cycle, 514 cycles after FETCH_T entry.
  - noe falls on the next cycle.
- Plane weighting: BASE_TICKS=64; measure noe-low lengths for row 0 -> 64, 128, 256, 512 cycles.
  - mux=0 during all four, then mux=1 for row 1.
- Bit select: pixel 12'h8C3 at addr 5 -> s_r_t for col 5 over planes 0..3 = 0,0,0,1.
  - s_g_t = 0,0,1,1.
  - s_b_t = 1,1,0,0.
- Frame and enable: enable high -> frame_done pulses 48256 cycles apart.
  - Drop enable mid-frame -> that frame completes, frame_done pulses, block enters IDLE (busy=0, noe=1).
